// File: rtl/prog_mem_loader.sv
// Writable instruction memory with a handshaked word loader and a combinational fetch port.
// Optional feature: define PROG_MEM_PARITY_EN for an even-parity bit on ld_data and a sticky err flag.
module prog_mem_loader #(
    parameter int unsigned      INS_W       = 21,
    parameter int unsigned      ADDR_W      = 8,
    parameter int unsigned      DEPTH       = 256,
    parameter logic [INS_W-1:0] HOLD_INS    = {2'b00, 1'b1, 4'b0111, 3'b000, 3'b000, 8'hFF},
    parameter logic [INS_W-1:0] DEFAULT_INS = {2'b01, 1'b0, 4'b0111, 3'b000, 3'b000, 8'h00}
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [INS_W-1:0]  fetch_ins,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              ld_valid,
`ifdef PROG_MEM_PARITY_EN
    input  logic [INS_W:0]    ld_data,
`else
    input  logic [INS_W-1:0]  ld_data,
`endif
    output logic              ld_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err
);

    localparam int unsigned       CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [INS_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]   len;

    logic               start;
    logic               xfer;
    logic               par_ok;
    logic [INS_W-1:0]   word;
    logic [CNT_W-1:0]   len_next;
    logic [CNT_W-1:0]   wr_count_inc;

    // Beat payload and parity status
`ifdef PROG_MEM_PARITY_EN
    always_comb begin
        word   = ld_data[INS_W-1:0];
        par_ok = ~(^ld_data);
    end
`else
    always_comb begin
        word   = ld_data;
        par_ok = 1'b1;
    end
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next   = state;
        start        = 1'b0;
        xfer         = 1'b0;
        len_next     = (load_len > DEPTH_C) ? DEPTH_C : load_len;
        wr_count_inc = wr_count + CNT_W'(1);
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    start      = 1'b1;
                    state_next = (len_next == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                xfer = ld_valid;
                if ((xfer && (wr_count_inc == len)) || load_abort) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counters, valid map and status flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            valid    <= '0;
            wr_ptr   <= '0;
            wr_count <= '0;
            len      <= '0;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ld_ready <= (state_next == S_LOAD);
            busy     <= (state_next != S_IDLE);
            done     <= (state_next == S_DONE);
            if (start) begin
                valid    <= '0;
                wr_ptr   <= '0;
                wr_count <= '0;
                len      <= len_next;
            end
            if (xfer) begin
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                wr_count <= wr_count_inc;
                if (par_ok) begin
                    valid[wr_ptr] <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_MEM_PARITY_EN
    // Sticky parity error, cleared by reset or a new load
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (xfer && !par_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Storage array is not reset; the valid map guards every read
    always_ff @(posedge CLK) begin
        if (xfer && par_ok) begin
            mem[wr_ptr] <= word;
        end
    end

    // Combinational fetch port
    always_comb begin
        fetch_ins = DEFAULT_INS;
        if (busy) begin
            fetch_ins = HOLD_INS;
        end else if ((CNT_W'(fetch_addr) < DEPTH_C) && valid[fetch_addr]) begin
            fetch_ins = mem[fetch_addr];
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed load scenarios with random data
// checked against an array-based model of the program memory.
`timescale 1ns/1ps
module tb_prog_mem_loader;

    localparam int unsigned INS_W  = 21;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam logic [INS_W-1:0] HOLD    = {2'b00, 1'b1, 4'b0111, 3'b000, 3'b000, 8'hFF};
    localparam logic [INS_W-1:0] DEFAULT = {2'b01, 1'b0, 4'b0111, 3'b000, 3'b000, 8'h00};

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic [ADDR_W-1:0] fetch_addr;
    logic [INS_W-1:0]  fetch_ins;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              load_abort;
    logic              ld_valid;
`ifdef PROG_MEM_PARITY_EN
    logic [INS_W:0]    ld_data;
`else
    logic [INS_W-1:0]  ld_data;
`endif
    logic              ld_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              err;

    int n_pass  = 0;
    int n_total = 0;

    logic [INS_W-1:0] m_mem   [DEPTH];
    bit               m_valid [DEPTH];
    bit               m_err;

    prog_mem_loader dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .fetch_addr (fetch_addr),
        .fetch_ins  (fetch_ins),
        .load_start (load_start),
        .load_len   (load_len),
        .load_abort (load_abort),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_word(input logic [INS_W-1:0] w, input bit bad);
`ifdef PROG_MEM_PARITY_EN
        ld_data = {(^w) ^ bad, w};
`else
        ld_data = w;
        if (bad) ld_data = w;
`endif
    endtask

    // Compare every fetch address against the model while idle
    task automatic sweep(input string tag);
        logic [INS_W-1:0] exp;
        for (int a = 0; a < DEPTH; a++) begin
            fetch_addr = ADDR_W'(a);
            #0.1;
            exp = m_valid[a] ? m_mem[a] : DEFAULT;
            chk($sformatf("%s_addr%0d", tag, a), fetch_ins, exp);
        end
    endtask

    // mode 0: ld_valid always high, 1: toggling, 2: random
    task automatic run_load(input int len_in, input int mode, input int abort_at,
                            input int bad_at, input int exp_cyc);
        int               idx;
        int               cyc;
        int               n_eff;
        bit               got_done;
        bit               v;
        logic [INS_W-1:0] w;
        n_eff = (len_in > DEPTH) ? DEPTH : len_in;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_err = 1'b0;
        idx   = 0;
        @(negedge CLK);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len_in);
        @(negedge CLK);
        load_start = 1'b0;
        cyc        = 1;
        got_done   = 1'b0;
        while (!got_done && cyc < 1000) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                fetch_addr = ADDR_W'($urandom);
                #0.1;
                chk("hold_ins", fetch_ins, HOLD);
                chk("ld_ready_in_load", ld_ready, 1);
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2) == 1;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                w        = INS_W'($urandom);
                ld_valid = v;
                drive_word(w, (idx == bad_at));
                if (v && idx < n_eff) begin
                    if (abort_at == idx + 1) load_abort = 1'b1;
                    if (idx == bad_at) begin
                        m_err = 1'b1;
                    end else begin
                        m_mem[idx]   = w;
                        m_valid[idx] = 1'b1;
                    end
                    idx = idx + 1;
                end
                @(negedge CLK);
                ld_valid   = 1'b0;
                load_abort = 1'b0;
                cyc        = cyc + 1;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("wr_count", wr_count, idx);
        chk("busy_with_done", busy, 1);
        chk("ready_in_done", ld_ready, 0);
        chk("err", err, m_err);
        if (exp_cyc >= 0) chk("done_cycle", cyc, exp_cyc);
        @(negedge CLK);
        chk("done_pulse_1cyc", done, 0);
        chk("busy_after_done", busy, 0);
        sweep($sformatf("load%0d", len_in));
    endtask

    initial begin
        RESET_N    = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_len   = '0;
        load_abort = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_err = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Reset state
        fetch_addr = 8'd0;   #0.1; chk("rst_fetch0", fetch_ins, DEFAULT);
        fetch_addr = 8'd7;   #0.1; chk("rst_fetch7", fetch_ins, DEFAULT);
        fetch_addr = 8'd255; #0.1; chk("rst_fetch255", fetch_ins, DEFAULT);
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_err", err, 0);

        // 7-word program at full rate
        run_load(7, 0, 0, -1, 8);

        // Beats offered in IDLE are dropped
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            ld_valid = 1'b1;
            drive_word(INS_W'($urandom), 1'b0);
            chk("idle_ld_ready", ld_ready, 0);
        end
        @(negedge CLK);
        ld_valid = 1'b0;
        sweep("idle_drop");

        // Toggling valid, abort on the 3rd transfer, random pacing
        run_load(4, 1, 0, -1, 8);
        run_load(10, 0, 3, -1, 4);
        run_load(int'($urandom_range(1, 40)), 2, 0, -1, -1);

        // Reset after 5 of 8 words
        @(negedge CLK);
        load_start = 1'b1;
        load_len   = 9'd8;
        @(negedge CLK);
        load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ld_valid = 1'b1;
            drive_word(INS_W'($urandom), 1'b0);
            @(negedge CLK);
        end
        ld_valid = 1'b0;
        chk("midload_wr_count", wr_count, 5);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ld_ready", ld_ready, 0);
        chk("midrst_wr_count", wr_count, 0);
        sweep("midrst");

        // Zero length and oversized length
        run_load(0, 0, 0, -1, 1);
        run_load(300, 0, 0, -1, DEPTH + 1);

`ifdef PROG_MEM_PARITY_EN
        run_load(4, 0, 0, 2, 5);
        run_load(3, 0, 0, -1, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Writable, parametrised instruction memory that replaces the fixed program ROM in front of the CPU's fetch port. A handshaked loader writes a program word by word, and the CPU reads through a combinational fetch port. While a load is in progress the fetch port returns a hold instruction. After reset or a partial load, unwritten words return a default instruction, so the CPU always sees a defined opcode.

## Interface
Parameters:
- `INS_W`, 21: instruction width.
- `ADDR_W`, 8: fetch and write address width.
- `DEPTH`, 256: number of words; must be ≤ 2^`ADDR_W`.
- `HOLD_INS`, `{2'b00,1'b1,4'b0111,3'b000,3'b000,8'hFF}`: word returned while loading.
- `DEFAULT_INS`, `{2'b01,1'b0,4'b0111,3'b000,3'b000,8'h00}`: word returned for unwritten or out-of-range addresses.

Ports:
- `CLK`  in  1: the one clock; all state updates on its rising edge.
- `RESET_N`  in  1: synchronous, active-low reset.
- `fetch_addr`  in  `ADDR_W`: CPU fetch address.
- `fetch_ins`  out  `INS_W`: instruction; combinational from `fetch_addr` and state.
- `load_start`  in  1: begin a load; sampled in IDLE only.
- `load_len`  in  `ADDR_W`+1: number of words to load; sampled with `load_start`.
- `load_abort`  in  1: terminate a load early.
- `ld_valid`  in  1: load word valid.
- `ld_data`  in  `INS_W` (or `INS_W`+1 with parity, see Configuration): load word.
- `ld_ready`  out  1: loader accepts a word this cycle.
- `busy`  out  1: high in the LOAD or DONE state.
- `done`  out  1: one-cycle pulse at the end of a load.
- `wr_count`  out  `ADDR_W`+1: words written by the current or last load.
- `err`  out  1: sticky parity error; 0 when parity is compiled out.

## Operation
- Storage is a `DEPTH`×`INS_W` array plus a `DEPTH`-bit valid map. Only the valid map, FSM and counters are reset; array contents are not.
- States:
  - IDLE → LOAD on `load_start`. On that edge: clear the whole valid map, set `wr_ptr`=0, set `wr_count`=0, latch `len` = min(`load_len`, `DEPTH`).
  - If the latched length is 0, go IDLE → DONE directly, with no writes.
  - LOAD: `ld_ready`=1. A transfer happens on `ld_valid`&`ld_ready`. Each transfer writes `mem[wr_ptr]`, sets `valid[wr_ptr]`, and increments `wr_ptr` and `wr_count`.
  - LOAD → DONE on the transfer that makes `wr_count`==`len`.
  - LOAD → DONE on `load_abort`. If abort coincides with a transfer, the word is written first.
  - DONE: `done`=1 for exactly one cycle, then DONE → IDLE.
- `load_start` is ignored outside IDLE. `load_abort` is ignored outside LOAD.
- Fetch read:
  - `busy`=1: `HOLD_INS`.
  - Otherwise, `fetch_addr` ≥ `DEPTH` or `valid[fetch_addr]`=0: `DEFAULT_INS`.
  - Otherwise: `mem[fetch_addr]`.
- `ld_data` arriving outside LOAD is dropped; `ld_ready`=0 there.

## Timing
- Reset values: state IDLE, valid map all 0, `wr_ptr`=0, `wr_count`=0, `ld_ready`=0, `busy`=0, `done`=0, `err`=0, `fetch_ins`=`DEFAULT_INS`.
- Reset mid-load returns to IDLE with the valid map cleared. Any partially written program is invisible.
- `ld_ready` rises in the cycle after the `load_start` edge.
- Throughput: one word per cycle. Minimum load time is N+1 cycles for N words (N write cycles plus the DONE cycle).
- A write on edge k is visible at `fetch_ins` once `busy` drops, i.e. the cycle after DONE.
- Fetch has zero-cycle latency (combinational) and is drop-in for the old ROM.
- `done` and `busy`=1 are high in the same cycle. `busy` falls on the edge that leaves DONE.

## Configuration
- `PROG_MEM_PARITY_EN` defined:
  - `ld_data` is `INS_W`+1 bits; bit `INS_W` is an even-parity bit over `ld_data[INS_W-1:0]`.
  - A beat with bad parity is still handshaken and still advances `wr_ptr` and `wr_count`. Its word is not written, and its valid bit stays 0.
  - `err` sets on a bad beat and holds until reset or the next `load_start`.
- `PROG_MEM_PARITY_EN` undefined: `ld_data` is `INS_W` bits; `err` is tied to 0.

## Test plan
- Reset, then fetch at addresses 0, 7 and 255 → `DEFAULT_INS` at each; `busy`=0, `ld_ready`=0.
- Load 7 words (the 7-instruction test program) with `ld_valid` held high → `ld_ready` high for 7 cycles, `done` pulses in cycle 8, `wr_count`=7. Afterwards fetch 0..6 returns the loaded words and fetch 7 returns `DEFAULT_INS`.
- Load of 4 words with `ld_valid` toggling every other cycle → 4 writes in 8 cycles; `fetch_ins`=`HOLD_INS` throughout; no extra writes.
- `load_abort` asserted together with the 3rd transfer of a 10-word load → words 0..2 valid, 3..9 default, one `done` pulse, `wr_count`=3.
- `RESET_N`=0 after 5 of 8 words → IDLE next cycle; all fetches return `DEFAULT_INS`. `load_len`=0 → `done` 1 cycle after start with no writes. `load_len`=300 with `DEPTH`=256 → exactly 256 writes.
- `PROG_MEM_PARITY_EN` defined, bad parity on word 2 of 4 → `err`=1; address 2 returns `DEFAULT_INS`; `wr_count`=4; the next `load_start` clears `err`.
